// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, echo FSM states and a
// saturating add used by the audio processing stages.
package audio_pkg;

  localparam int N = 24;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD_L,
    CALC_L,
    WR_L,
    RD_R,
    CALC_R,
    WR_R
  } state_t;

  // Adds two sign-extended operands and clamps to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port delay-line RAM: synchronous write, registered read, one access per cycle.
module echo_ram #(
  parameter int N  = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/audio_echo.sv
// Stereo echo: per frame, adds an attenuated delayed sample to each channel input.
// Define AUDIO_ECHO_FEEDBACK_EN to store the wet result (recirculating echo).
module audio_echo #(
  parameter int N     = audio_pkg::N,
  parameter int AW    = 10,
  parameter int SHIFT = 1
) (
  input  logic                audio_clk,
  input  logic                reset,
  input  logic                NewFrame,
  input  logic signed [N-1:0] LeftRecData,
  input  logic signed [N-1:0] RightRecData,
  input  logic [AW-1:0]       delay_len,
  input  logic                bypass,
  output logic signed [N-1:0] LeftPlayData,
  output logic signed [N-1:0] RightPlayData,
  output logic                ready,
  output logic                overrun
);
  import audio_pkg::*;

  localparam int RAW = AW + 1;

  state_t              state, state_nxt;
  logic                nf_q, accept, dry;
  logic [RAW-1:0]      clr_cnt;
  logic [AW-1:0]       wr_ptr, rd_ptr, dly_q;
  logic                byp_q;
  logic signed [N-1:0] in_l, in_r, y_l, y_r, in_sel, echo, y_calc, wr_l, wr_r;
  logic                ram_en, ram_we;
  logic [RAW-1:0]      ram_addr;
  logic [N-1:0]        ram_wdata, ram_rdata;

  assign accept = NewFrame & ~nf_q;
  assign ready  = (state != CLEAR);
  assign rd_ptr = wr_ptr - dly_q;
  assign dry    = byp_q | (dly_q == '0);
  assign in_sel = (state == CALC_R) ? in_r : in_l;
  assign echo   = $signed(ram_rdata) >>> SHIFT;
  assign y_calc = dry ? in_sel : N'(sat_add(64'(in_sel), 64'(echo), N));

`ifdef AUDIO_ECHO_FEEDBACK_EN
  // y already equals the input when bypassed or delay is zero
  assign wr_l = y_l;
  assign wr_r = y_r;
`else
  assign wr_l = in_l;
  assign wr_r = in_r;
`endif

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        if (&clr_cnt) state_nxt = IDLE;
      end
      IDLE:   if (accept) state_nxt = RD_L;
      RD_L: begin
        ram_en    = 1'b1;
        ram_addr  = {rd_ptr, 1'b0};
        state_nxt = CALC_L;
      end
      CALC_L: state_nxt = WR_L;
      WR_L: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {wr_ptr, 1'b0};
        ram_wdata = wr_l;
        state_nxt = RD_R;
      end
      RD_R: begin
        ram_en    = 1'b1;
        ram_addr  = {rd_ptr, 1'b1};
        state_nxt = CALC_R;
      end
      CALC_R: state_nxt = WR_R;
      WR_R: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {wr_ptr, 1'b1};
        ram_wdata = wr_r;
        state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (reset) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      wr_ptr        <= '0;
      LeftPlayData  <= '0;
      RightPlayData <= '0;
      overrun       <= 1'b0;
      nf_q          <= 1'b0;
    end else begin
      state <= state_nxt;
      nf_q  <= NewFrame;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      // edges during CLEAR are ignored outright, not counted as overruns
      if (accept && state != IDLE && state != CLEAR) overrun <= 1'b1;
      if (state == WR_R) begin
        LeftPlayData  <= y_l;
        RightPlayData <= y_r;
        wr_ptr        <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge audio_clk) begin
    if (state == IDLE && accept) begin
      in_l  <= LeftRecData;
      in_r  <= RightRecData;
      dly_q <= delay_len;
      byp_q <= bypass;
    end
    if (state == CALC_L) y_l <= y_calc;
    if (state == CALC_R) y_r <= y_calc;
  end

  echo_ram #(.N(N), .AW(RAW)) u_ram (
    .clk   (audio_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_audio_echo.sv
// Directed bench for audio_echo (N=24, AW=3, SHIFT=1) with a small per-frame echo model.
module tb_audio_echo;

  localparam int N  = 24;
  localparam int AW = 3;
  localparam int M  = 2 ** (AW + 1);
`ifdef AUDIO_ECHO_FEEDBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic                audio_clk = 1'b0;
  logic                reset = 1'b1;
  logic                NewFrame = 1'b0;
  logic signed [N-1:0] LeftRecData = '0;
  logic signed [N-1:0] RightRecData = '0;
  logic [AW-1:0]       delay_len = '0;
  logic                bypass = 1'b0;
  logic signed [N-1:0] LeftPlayData, RightPlayData;
  logic                ready, overrun;

  int checks = 0;
  int errors = 0;
  int fk;
  int st_l [64];
  int st_r [64];
  bit ovr_exp;

  always #5 audio_clk = ~audio_clk;

  audio_echo #(.N(N), .AW(AW), .SHIFT(1)) dut (
    .audio_clk     (audio_clk),
    .reset         (reset),
    .NewFrame      (NewFrame),
    .LeftRecData   (LeftRecData),
    .RightRecData  (RightRecData),
    .delay_len     (delay_len),
    .bypass        (bypass),
    .LeftPlayData  (LeftPlayData),
    .RightPlayData (RightPlayData),
    .ready         (ready),
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int sat24(input int v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  task automatic do_reset();
    int cnt;
    reset = 1'b1;
    NewFrame = 1'b0;
    repeat (3) @(negedge audio_clk);
    chk("rst_left", int'(LeftPlayData), 0);
    chk("rst_right", int'(RightPlayData), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    cnt = 0;
    // NewFrame toggles throughout the clear and must be ignored
    while (!ready && cnt < 4 * M) begin
      cnt++;
      NewFrame = cnt[0];
      @(negedge audio_clk);
    end
    NewFrame = 1'b0;
    chk("ready_low_cycles", cnt, M);
    @(negedge audio_clk);
    chk("clr_overrun", int'(overrun), 0);
    chk("clr_left", int'(LeftPlayData), 0);
    chk("clr_right", int'(RightPlayData), 0);
    fk = 0;
    ovr_exp = 1'b0;
    for (int i = 0; i < 64; i++) begin
      st_l[i] = 0;
      st_r[i] = 0;
    end
  endtask

  // hold: cycles NewFrame stays high; dbl: second edge three cycles after the first
  task automatic frame(input string tag, input int l, input int r, input int d,
                       input bit b, input int hold, input bit dbl);
    int  n, dl, dr, el, er;
    bit  dry;
    LeftRecData  = N'(l);
    RightRecData = N'(r);
    delay_len    = AW'(d);
    bypass       = b;
    NewFrame     = 1'b1;
    n = 0;
    if (dbl) begin
      @(negedge audio_clk); NewFrame = 1'b0;
      repeat (2) @(negedge audio_clk);
      NewFrame = 1'b1;
      @(negedge audio_clk); NewFrame = 1'b0;
      n = 4;
      ovr_exp = 1'b1;
    end else begin
      repeat (hold) @(negedge audio_clk);
      NewFrame = 1'b0;
      n = hold;
    end
    repeat (10 - n) @(negedge audio_clk);
    dry = b || (d == 0);
    dl  = (fk >= d) ? st_l[fk - d] : 0;
    dr  = (fk >= d) ? st_r[fk - d] : 0;
    el  = dry ? l : sat24(l + (dl >>> 1));
    er  = dry ? r : sat24(r + (dr >>> 1));
    st_l[fk] = (FB && !dry) ? el : l;
    st_r[fk] = (FB && !dry) ? er : r;
    chk($sformatf("%s_l%0d", tag, fk), int'(LeftPlayData), el);
    chk($sformatf("%s_r%0d", tag, fk), int'(RightPlayData), er);
    chk($sformatf("%s_ovr%0d", tag, fk), int'(overrun), int'(ovr_exp));
    fk++;
  endtask

  initial begin
    do_reset();

    // impulse: echo at frame 4, and again at frame 8 when recirculating
    for (int k = 0; k < 10; k++)
      frame("imp", (k == 0) ? 'h100000 : 0, (k == 0) ? -'h200000 : 0, 4, 1'b0, 1, 1'b0);
    chk("imp_f4_hand", st_l[0] >>> 1, 'h080000);

    do_reset();
    for (int k = 0; k < 3; k++)
      frame("sat", 'h7FFFF0, -'h800000, 1, 1'b0, 1, 1'b0);
    chk("sat_pos_hand", int'(LeftPlayData), 'h7FFFFF);
    chk("sat_neg_hand", int'(RightPlayData), -'h800000);

    do_reset();
    LeftRecData  = 24'h000123;
    RightRecData = 24'h000456;
    delay_len    = '0;
    bypass       = 1'b0;
    NewFrame     = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge audio_clk);
      NewFrame = 1'b0;
    end
    chk("lat_before", int'(LeftPlayData), 0);
    @(negedge audio_clk);
    chk("lat_left", int'(LeftPlayData), 'h123);
    chk("lat_right", int'(RightPlayData), 'h456);

    do_reset();
    frame("hold4", 'h10, 'h30, 2, 1'b0, 4, 1'b0);
    frame("after_hold", 0, 0, 1, 1'b0, 1, 1'b0);
    frame("ovr", 'h20, -5, 0, 1'b0, 1, 1'b1);
    frame("post_ovr", 0, 0, 3, 1'b0, 1, 1'b0);
    chk("post_ovr_hand", int'(LeftPlayData), 8);

    // ramp across the wr_ptr wrap at frame 8
    do_reset();
    for (int k = 0; k < 12; k++)
      frame("ramp", k + 1, -3 * (k + 1), 3, 1'b0, 1, 1'b0);

    do_reset();
    for (int k = 0; k < 8; k++)
      frame("byp", 'h1000 * (k + 1), -'h800 * (k + 1), 2, (k == 3 || k == 4), 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_echo.md
AUDIO_ECHO -- requirements
Module: audio_echo

Interface
- REQ-001: Parameter N, default 24; signed sample width in bits.
- REQ-002: Parameter AW, default 10; delay-line address width in frames, giving a depth of 2^AW frames per channel.
- REQ-003: Parameter SHIFT, default 1; attenuation of the echo term as an arithmetic right shift.
- REQ-004: audio_clk  input  1  the single clock; all flops update on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: NewFrame  input  1  frame marker from the codec interface; may stay high for several audio_clk cycles.
- REQ-007: LeftRecData  input  N  left recorded sample, signed.
- REQ-008: RightRecData  input  N  right recorded sample, signed.
- REQ-009: delay_len  input  AW  echo delay in frames; sampled on each accepted frame.
- REQ-010: bypass  input  1  when 1, the play outputs equal the rec inputs.
- REQ-011: LeftPlayData  output  N  left processed sample, registered.
- REQ-012: RightPlayData  output  N  right processed sample, registered.
- REQ-013: ready  output  1  high once the delay-line clear has finished.
- REQ-014: overrun  output  1  sticky flag: a frame arrived while the block was busy.

Function
- REQ-015: A frame is accepted on the first audio_clk cycle in which NewFrame=1 and its registered previous value is 0 (rising-edge detect).
- REQ-016: FSM states are CLEAR, IDLE, RD_L, CALC_L, WR_L, RD_R, CALC_R, WR_R.
- REQ-017: On an accepted frame in IDLE, LeftRecData, RightRecData, delay_len and bypass are captured and the FSM moves to RD_L.
- REQ-018: The FSM sequence is RD_L -> CALC_L -> WR_L -> RD_R -> CALC_R -> WR_R -> IDLE, one state per cycle.
- REQ-019: RAM address is {ptr, ch}, with ch=0 for left and ch=1 for right.
- REQ-020: Read address = wr_ptr - delay_len, modulo 2^AW.
- REQ-021: Write address = wr_ptr.
- REQ-022: RAM read latency is 1 cycle; read data is used in CALC_x.
- REQ-023: In CALC_x, y = in + (delayed >>> SHIFT), computed at N+1 bits, then saturated to the N-bit signed range [-2^(N-1), 2^(N-1)-1].
- REQ-024: delay_len=0 forces y = in; the buffer is still written.
- REQ-025: bypass=1 forces y = in; the buffer is still written.
- REQ-026: In WR_x, the stored value is the captured input sample for that channel (dry path).
- REQ-027: LeftPlayData and RightPlayData both update together in the cycle WR_R -> IDLE; latency from the accepted edge to the outputs is 7 cycles.
- REQ-028: Outputs hold their value between updates.
- REQ-029: wr_ptr increments by 1 per completed frame and wraps from 2^AW-1 to 0.
- REQ-030: An accepted NewFrame edge while the FSM is not in IDLE is dropped and sets overrun=1.
- REQ-031: overrun is cleared only by reset.
- REQ-032: In CLEAR, the block writes 0 to addresses 0 .. 2^(AW+1)-1, one address per cycle, then enters IDLE and sets ready=1.
- REQ-033: NewFrame edges during CLEAR are ignored and do not set overrun.

Reset
- REQ-034: While reset=1: state=CLEAR, clear counter=0, wr_ptr=0, LeftPlayData=0, RightPlayData=0, ready=0, overrun=0, edge-detect register=0.
- REQ-035: Reset asserted mid-frame or mid-CLEAR aborts the operation; after release, CLEAR restarts from address 0.

Configuration
- REQ-036: The macro AUDIO_ECHO_FEEDBACK_EN selects the value written to the delay line.
- REQ-037: With AUDIO_ECHO_FEEDBACK_EN defined, WR_x stores the saturated y, giving a recirculating echo; with bypass=1 or delay_len=0 it stores the input.
- REQ-038: Without AUDIO_ECHO_FEEDBACK_EN, WR_x stores the dry input per REQ-026, giving a single echo.

Structure
- REQ-039: Package audio_pkg holds N, the FSM state enum and a saturating-add function shared with other audio stages.
- REQ-040: One sub-module, echo_ram: single-port RAM of 2^(AW+1) x N with synchronous read and synchronous write, one access per cycle; the FSM never reads and writes in the same cycle.

Verification
- REQ-041: Reset held 3 cycles, then released -> ready=0 for exactly 2^(AW+1) cycles, then 1; play outputs remain 0.
- REQ-042: delay_len=4, SHIFT=1, left impulse 0x100000 in frame 0 then zeros -> LeftPlayData=0x100000 at frame 0, 0x080000 at frame 4, 0 elsewhere; with AUDIO_ECHO_FEEDBACK_EN also 0x040000 at frame 8.
- REQ-043: Left input 0x7FFFF0 constant, delay_len=1 -> from frame 1, LeftPlayData=0x7FFFFF (saturated); input 0x800000 constant -> 0x800000.
- REQ-044: NewFrame held high for 4 cycles -> exactly one frame processed; second NewFrame edge 3 cycles after the first -> overrun=1 and output matches the single-frame result.
- REQ-045: AW=2, delay_len=3, ramp inputs 1, 2, 3, ... over 10 frames -> the echo term tracks input[k-3]>>>1 across the wr_ptr wrap at frame 4.
- REQ-046: bypass=1 mid-stream -> outputs equal the inputs with 7-cycle latency; the echo resumes correctly after bypass returns to 0.
